// File: rtl/mul_issue_unit.sv
// ============================================================================
// Module   : mul_issue_unit
// Purpose  : Issue/retire wrapper around a fixed-latency streaming multiplier.
//            Accepts requests over valid/ready, registers operands into the
//            core, tracks tags through a latency-matched pipe and captures
//            results into a small writeback FIFO. Credit-based issue keeps
//            the FIFO from ever overflowing, since the core cannot stall.
// Options  : MUL_ISSUE_ZERO_BYPASS_EN - ops with a zero operand skip the core
//            and retire with result 0 / overflow 0 at unchanged latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_issue_unit #(
  parameter int WORD_WIDTH  = 32,
  parameter int TAG_WIDTH   = 5,
  parameter int MUL_LATENCY = 5,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WORD_WIDTH-1:0] req_a,
  input  logic [WORD_WIDTH-1:0] req_b,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic [WORD_WIDTH-1:0] mul_multiplicand,
  output logic [WORD_WIDTH-1:0] mul_multiplier,
  input  logic [WORD_WIDTH-1:0] mul_result,
  input  logic                  mul_overflow,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [WORD_WIDTH-1:0] wb_result,
  output logic [TAG_WIDTH-1:0]  wb_tag,
  output logic                  wb_overflow,
  output logic                  busy
);

  // One extra stage: operands are registered one cycle before the core sees them.
  localparam int STAGES = MUL_LATENCY + 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W  = $clog2(STAGES + 1);
  localparam int SUM_W  = ((INF_W > CNT_W) ? INF_W : CNT_W) + 1;

  logic [STAGES-1:0]     pipe_valid;
  logic [TAG_WIDTH-1:0]  pipe_tag [STAGES];

  logic [WORD_WIDTH-1:0] fifo_result [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]  fifo_tag    [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_ovf;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      fifo_count;

  logic [INF_W-1:0]      inflight;
  logic [SUM_W-1:0]      credits_used;
  logic                  accept;
  logic                  issue_to_core;
  logic                  push;
  logic                  pop;
  logic [WORD_WIDTH-1:0] push_result;
  logic                  push_ovf;

`ifdef MUL_ISSUE_ZERO_BYPASS_EN
  logic [STAGES-1:0]     pipe_zero;
  logic                  req_zero;
  assign req_zero      = (req_a == '0) || (req_b == '0);
  assign issue_to_core = accept && !req_zero;
  assign push_result   = pipe_zero[STAGES-1] ? '0   : mul_result;
  assign push_ovf      = pipe_zero[STAGES-1] ? 1'b0 : mul_overflow;
`else
  assign issue_to_core = accept;
  assign push_result   = mul_result;
  assign push_ovf      = mul_overflow;
`endif

  // Count ops currently travelling through the tag pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < STAGES; i++) begin
      inflight = inflight + INF_W'(pipe_valid[i]);
    end
  end

  // Every in-flight op owns a FIFO slot, so a result always has somewhere to land.
  assign credits_used = SUM_W'(inflight) + SUM_W'(fifo_count);
  assign req_ready    = !reset && !flush && (credits_used < SUM_W'(FIFO_DEPTH));
  assign accept       = req_valid && req_ready;

  assign wb_valid    = (fifo_count != '0);
  assign pop         = wb_valid && wb_ready;
  assign push        = pipe_valid[STAGES-1] && !reset && !flush;
  assign wb_result   = fifo_result[rd_ptr];
  assign wb_tag      = fifo_tag[rd_ptr];
  assign wb_overflow = fifo_ovf[rd_ptr];
  assign busy        = (|pipe_valid) || (fifo_count != '0);

  // Operand registers feeding the core; they hold their value when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
    end else if (issue_to_core) begin
      mul_multiplicand <= req_a;
      mul_multiplier   <= req_b;
    end
  end

  // Valid pipe shifts every cycle; flush or reset kills everything in flight.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid <= {pipe_valid[STAGES-2:0], accept};
    end
  end

  // Tag pipe is qualified by pipe_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    pipe_tag[0] <= req_tag;
    for (int i = 1; i < STAGES; i++) begin
      pipe_tag[i] <= pipe_tag[i-1];
    end
  end

`ifdef MUL_ISSUE_ZERO_BYPASS_EN
  // Zero-operand flag travels alongside the tag.
  always_ff @(posedge clk) begin
    pipe_zero <= {pipe_zero[STAGES-2:0], req_zero};
  end
`endif

  // FIFO storage written with the core output when the last pipe stage is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_result[wr_ptr] <= push_result;
      fifo_tag[wr_ptr]    <= pipe_tag[STAGES-1];
      fifo_ovf[wr_ptr]    <= push_ovf;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_issue_unit.sv
// ============================================================================
// Module   : tb_mul_issue_unit
// Purpose  : Self-checking bench for mul_issue_unit. A behavioural multiplier
//            core sits on the mul_* ports; a queue-based reference model
//            predicts handshake, writeback and busy behaviour each cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_issue_unit;

  localparam int WORD_WIDTH  = 32;
  localparam int TAG_WIDTH   = 5;
  localparam int MUL_LATENCY = 5;
  localparam int FIFO_DEPTH  = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  flush;
  logic                  req_valid;
  logic                  req_ready;
  logic [WORD_WIDTH-1:0] req_a;
  logic [WORD_WIDTH-1:0] req_b;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic [WORD_WIDTH-1:0] mul_multiplicand;
  logic [WORD_WIDTH-1:0] mul_multiplier;
  logic [WORD_WIDTH-1:0] mul_result;
  logic                  mul_overflow;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [WORD_WIDTH-1:0] wb_result;
  logic [TAG_WIDTH-1:0]  wb_tag;
  logic                  wb_overflow;
  logic                  busy;

  mul_issue_unit #(
    .WORD_WIDTH (WORD_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .MUL_LATENCY(MUL_LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_a           (req_a),
    .req_b           (req_b),
    .req_tag         (req_tag),
    .mul_multiplicand(mul_multiplicand),
    .mul_multiplier  (mul_multiplier),
    .mul_result      (mul_result),
    .mul_overflow    (mul_overflow),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_result       (wb_result),
    .wb_tag          (wb_tag),
    .wb_overflow     (wb_overflow),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Behavioural streaming multiplier: unsigned product, MUL_LATENCY registers deep.
  logic [2*WORD_WIDTH-1:0] mprod [MUL_LATENCY];
  always @(posedge clk) begin
    mprod[0] <= (2*WORD_WIDTH)'(mul_multiplicand) * (2*WORD_WIDTH)'(mul_multiplier);
    for (int i = 1; i < MUL_LATENCY; i++) mprod[i] <= mprod[i-1];
  end
  assign mul_result   = mprod[MUL_LATENCY-1][WORD_WIDTH-1:0];
  assign mul_overflow = |mprod[MUL_LATENCY-1][2*WORD_WIDTH-1:WORD_WIDTH];

  // Reference model: ops in flight with their age, and the writeback queue.
  typedef struct packed {
    logic [WORD_WIDTH-1:0] res;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  ovf;
  } exp_t;

  exp_t                  fifo_q [$];
  exp_t                  fl_ent [$];
  int                    fl_age [$];
  logic [WORD_WIDTH-1:0] exp_mc = '0;
  logic [WORD_WIDTH-1:0] exp_mp = '0;
  int                    n_tests = 0;
  int                    n_fail  = 0;
  bit                    last_acc;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t make_exp(input logic [WORD_WIDTH-1:0] a,
                                    input logic [WORD_WIDTH-1:0] b,
                                    input logic [TAG_WIDTH-1:0] t);
    logic [2*WORD_WIDTH-1:0] p;
    exp_t e;
    p     = (2*WORD_WIDTH)'(a) * (2*WORD_WIDTH)'(b);
    e.res = p[WORD_WIDTH-1:0];
    e.ovf = |p[2*WORD_WIDTH-1:WORD_WIDTH];
    e.tag = t;
    return e;
  endfunction

  task automatic drive(input bit v, input logic [WORD_WIDTH-1:0] a,
                       input logic [WORD_WIDTH-1:0] b, input logic [TAG_WIDTH-1:0] t,
                       input bit wr, input bit fl, input bit rst);
    req_valid = v; req_a = a; req_b = b; req_tag = t;
    wb_ready = wr; flush = fl; reset = rst;
  endtask

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic tick();
    bit exp_rdy, acc, v_rst, v_fl, v_wr;
    logic [WORD_WIDTH-1:0] va, vb;
    logic [TAG_WIDTH-1:0] vt;
    int inflight;
    #1;
    inflight = fl_ent.size();
    exp_rdy  = !reset && !flush && ((inflight + fifo_q.size()) < FIFO_DEPTH);
    check("req_ready", req_ready, exp_rdy);
    check("wb_valid", wb_valid, fifo_q.size() != 0);
    if (fifo_q.size() != 0) begin
      check("wb_result", wb_result, fifo_q[0].res);
      check("wb_tag", wb_tag, fifo_q[0].tag);
      check("wb_overflow", wb_overflow, fifo_q[0].ovf);
    end
    check("busy", busy, (inflight != 0) || (fifo_q.size() != 0));
    check("mul_multiplicand", mul_multiplicand, exp_mc);
    check("mul_multiplier", mul_multiplier, exp_mp);
    check("fifo_bound", int'(dut.fifo_count) <= FIFO_DEPTH, 1);
    acc      = req_valid && exp_rdy;
    last_acc = req_valid && req_ready;
    v_rst = reset; v_fl = flush; v_wr = wb_ready;
    va = req_a; vb = req_b; vt = req_tag;
    @(posedge clk);
    if (v_rst || v_fl) begin
      fifo_q.delete(); fl_ent.delete(); fl_age.delete();
      if (v_rst) begin exp_mc = '0; exp_mp = '0; end
    end else begin
      if (fifo_q.size() != 0 && v_wr) void'(fifo_q.pop_front());
      foreach (fl_age[i]) fl_age[i]++;
      if (fl_age.size() != 0 && fl_age[0] == MUL_LATENCY + 1) begin
        fifo_q.push_back(fl_ent.pop_front());
        void'(fl_age.pop_front());
      end
      if (acc) begin
        fl_ent.push_back(make_exp(va, vb, vt));
        fl_age.push_back(0);
`ifdef MUL_ISSUE_ZERO_BYPASS_EN
        if (va != '0 && vb != '0)
`endif
        begin exp_mc = va; exp_mp = vb; end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit wr);
    for (int i = 0; i < n; i++) begin
      drive(0, '0, '0, '0, wr, 0, 0);
      tick();
    end
  endtask

  // Present one op until accepted, bounded.
  task automatic issue(input logic [WORD_WIDTH-1:0] a, input logic [WORD_WIDTH-1:0] b,
                       input logic [TAG_WIDTH-1:0] t, input bit wr, input string name);
    int k = 0;
    do begin
      drive(1, a, b, t, wr, 0, 0);
      tick();
      k++;
    end while (!last_acc && k < 40);
    check(name, last_acc, 1);
    drive(0, '0, '0, '0, wr, 0, 0);
  endtask

  function automatic logic [WORD_WIDTH-1:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return WORD_WIDTH'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc_cnt;
    drive(0, '0, '0, '0, 1, 0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    tick();                               // reset state, req_ready low during reset
    drive(0, '0, '0, '0, 1, 0, 0);

    // Single op: 7*6 tag 3, latency from accept edge to wb_valid
    issue(32'd7, 32'd6, 5'd3, 1, "single_accept");
    n = 0;
    while (!wb_valid && n < 20) begin
      drive(0, '0, '0, '0, 1, 0, 0);
      tick();
      n++;
    end
    check("single_latency", n, MUL_LATENCY + 1);
    check("single_result", wb_result, 42);
    check("single_tag", wb_tag, 3);
    idle(3, 1);

    // Overflow boundaries
    issue(32'h0001_0000, 32'h0001_0000, 5'd1, 1, "ovf_accept");
    issue(32'hFFFF_FFFF, 32'd1, 5'd2, 1, "max_accept");
    idle(MUL_LATENCY + 4, 1);

    // Backpressure: six back-to-back ops with writeback stalled
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, WORD_WIDTH'(i + 1), 32'd2, TAG_WIDTH'(i), 0, 0, 0);
      tick();
      if (last_acc) acc_cnt++;
    end
    check("bp_accepted", acc_cnt, FIFO_DEPTH);
    idle(MUL_LATENCY + 3, 0);
    issue(32'd5, 32'd2, 5'd4, 1, "bp_retry4");
    issue(32'd6, 32'd2, 5'd5, 1, "bp_retry5");
    idle(MUL_LATENCY + 6, 1);

    // Fill FIFO, then stream ops with writeback enabled (push and pop together)
    for (int i = 0; i < FIFO_DEPTH; i++) issue(WORD_WIDTH'(i + 10), 32'd3, TAG_WIDTH'(i), 0, "full_fill");
    idle(MUL_LATENCY + 3, 0);
    for (int i = 0; i < 8; i++) issue(WORD_WIDTH'(i + 20), 32'd5, TAG_WIDTH'(i + 8), 1, "full_stream");
    idle(MUL_LATENCY + 6, 1);

    // Flush: one queued result plus three in flight, request presented during flush
    issue(32'd3, 32'd3, 5'd9, 0, "fl_q");
    idle(MUL_LATENCY + 2, 0);
    for (int i = 0; i < 3; i++) issue(WORD_WIDTH'(i + 2), 32'd4, TAG_WIDTH'(i + 10), 0, "fl_inflight");
    drive(1, 32'd11, 32'd11, 5'd20, 0, 1, 0);
    tick();
    check("flush_not_accepted", last_acc, 0);
    idle(MUL_LATENCY + 4, 1);

    // Flush on the exact edge a result reaches the last stage
    issue(32'd8, 32'd8, 5'd7, 1, "fl_edge_op");
    idle(MUL_LATENCY, 1);
    drive(0, '0, '0, '0, 1, 1, 0);
    tick();
    idle(4, 1);

    // Reset with two ops in flight, then a fresh op
    issue(32'd12, 32'd12, 5'd1, 1, "rst_op0");
    issue(32'd13, 32'd13, 5'd2, 1, "rst_op1");
    drive(0, '0, '0, '0, 1, 0, 1);
    tick();
    idle(2, 1);
    issue(32'd9, 32'd9, 5'd6, 1, "post_rst_op");
    idle(MUL_LATENCY + 4, 1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 9) < 6, rand_word(), rand_word(), TAG_WIDTH'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1);
      tick();
    end
    idle(MUL_LATENCY + 8, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
